// File: rtl/pipelined_barrel_shifter.sv
// Pipelined log-shifter (SLL/SRL/SRA/ROL) with valid/ready flow control and a sideband tag.
// Define BSH_STICKY_EN to build the sticky (shifted-out OR) path for SRL/SRA.
module pipelined_barrel_shifter #(
    parameter int WIDTH       = 64,
    parameter int LVL_PER_STG = 2,
    parameter int TAG_W       = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_sticky
);

    localparam int SHW    = $clog2(WIDTH);
    localparam int STAGES = (SHW + LVL_PER_STG - 1) / LVL_PER_STG;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;

    logic w_adv;

    function automatic logic [WIDTH-1:0] shift_lvl(input logic [WIDTH-1:0] d,
                                                    input logic [1:0]       m,
                                                    input int               k);
        int amt;
        amt = 1 << k;
        case (m)
            MODE_SLL: shift_lvl = d << amt;
            MODE_SRL: shift_lvl = d >> amt;
            MODE_SRA: shift_lvl = $unsigned($signed(d) >>> amt);
            default:  shift_lvl = (d << amt) | (d >> (WIDTH - amt));
        endcase
    endfunction

`ifdef BSH_STICKY_EN
    // Bits falling off the bottom of a right shift at level k are d[2^k-1:0].
    function automatic logic lost_lvl(input logic [WIDTH-1:0] d,
                                      input logic [1:0]       m,
                                      input int               k);
        logic [WIDTH-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        if (m == MODE_SRL || m == MODE_SRA)
            lost_lvl = |(d & ((one << (1 << k)) - one));
        else
            lost_lvl = 1'b0;
    endfunction
`endif

    // Whole pipeline advances together; a full output slot only blocks when not being drained.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        localparam int LO = s * LVL_PER_STG;
        localparam int HI = (LO + LVL_PER_STG < SHW) ? (LO + LVL_PER_STG) : SHW;

        logic                  w_vld_in;
        logic [WIDTH-1:0]      w_data_in;
        logic [1:0]            w_mode_in;
        logic [SHW-LO-1:0]     w_shamt_in;
        logic [TAG_W-1:0]      w_tag_in;
        logic [WIDTH-1:0]      w_data_nxt;
        logic                  r_vld;
        logic [WIDTH-1:0]      r_data;
        logic [TAG_W-1:0]      r_tag;
`ifdef BSH_STICKY_EN
        logic                  w_stk_in;
        logic                  w_stk_nxt;
        logic                  r_stk;
`endif

        // Each stage only sees the shift-amount bits it has not yet consumed.
        if (s == 0) begin : g_src
            assign w_vld_in   = in_valid;
            assign w_data_in  = in_data;
            assign w_mode_in  = in_mode;
            assign w_shamt_in = in_shamt;
            assign w_tag_in   = in_tag;
`ifdef BSH_STICKY_EN
            assign w_stk_in   = 1'b0;
`endif
        end else begin : g_src
            assign w_vld_in   = g_stg[s-1].r_vld;
            assign w_data_in  = g_stg[s-1].r_data;
            assign w_mode_in  = g_stg[s-1].g_ctl.r_mode;
            assign w_shamt_in = g_stg[s-1].g_ctl.r_shamt;
            assign w_tag_in   = g_stg[s-1].r_tag;
`ifdef BSH_STICKY_EN
            assign w_stk_in   = g_stg[s-1].r_stk;
`endif
        end

`ifdef BSH_STICKY_EN
        always_comb begin
            w_data_nxt = w_data_in;
            w_stk_nxt  = w_stk_in;
            for (int j = 0; j < HI - LO; j++) begin
                if (w_shamt_in[j]) begin
                    w_stk_nxt  = w_stk_nxt | lost_lvl(w_data_nxt, w_mode_in, LO + j);
                    w_data_nxt = shift_lvl(w_data_nxt, w_mode_in, LO + j);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_stk <= 1'b0;
            else if (w_adv)
                r_stk <= w_stk_nxt;
        end
`else
        always_comb begin
            w_data_nxt = w_data_in;
            for (int j = 0; j < HI - LO; j++) begin
                if (w_shamt_in[j])
                    w_data_nxt = shift_lvl(w_data_nxt, w_mode_in, LO + j);
            end
        end
`endif

        // ---- stage register boundary ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld  <= 1'b0;
                r_data <= '0;
                r_tag  <= '0;
            end else if (w_adv) begin
                r_vld  <= w_vld_in;
                r_data <= w_data_nxt;
                r_tag  <= w_tag_in;
            end
        end

        if (HI < SHW) begin : g_ctl
            logic [1:0]        r_mode;
            logic [SHW-HI-1:0] r_shamt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mode  <= '0;
                    r_shamt <= '0;
                end else if (w_adv) begin
                    r_mode  <= w_mode_in;
                    r_shamt <= w_shamt_in[SHW-LO-1:HI-LO];
                end
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].r_vld;
    assign out_data  = g_stg[STAGES-1].r_data;
    assign out_tag   = g_stg[STAGES-1].r_tag;
`ifdef BSH_STICKY_EN
    assign out_sticky = g_stg[STAGES-1].r_stk;
`else
    assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (WIDTH=64, LVL_PER_STG=2): directed cases,
// backpressure, mid-flight reset and randomized traffic against an arithmetic reference model.
module tb_pipelined_barrel_shifter;

    localparam int LAT = 3;
`ifdef BSH_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [5:0]  in_shamt;
    logic [1:0]  in_mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_tag;
    logic        out_sticky;

    pipelined_barrel_shifter #(.WIDTH(64), .LVL_PER_STG(2), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_sticky(out_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  t;
        logic        st;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   chk_lat = 1'b0;
    int   ordy_mode = 0;   // 0: always ready, 1: never ready, 2: random

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_shift(input logic [63:0] d, input logic [5:0] sh,
                                              input logic [1:0] m);
        int n;
        n = int'(sh);
        case (m)
            2'd0: ref_shift = d << n;
            2'd1: ref_shift = d >> n;
            2'd2: ref_shift = $unsigned($signed(d) >>> n);
            default: ref_shift = (n == 0) ? d : ((d << n) | (d >> (64 - n)));
        endcase
    endfunction

    function automatic logic ref_sticky(input logic [63:0] d, input logic [5:0] sh,
                                        input logic [1:0] m);
        logic [63:0] lowmask;
        lowmask = (64'd1 << sh) - 64'd1;
        ref_sticky = STK && (m == 2'd1 || m == 2'd2) && ((d & lowmask) != 64'd0);
    endfunction

    task automatic push_exp(input logic [63:0] ed, input logic [3:0] t, input logic est);
        exp_t e;
        e.d = ed; e.t = t; e.st = est; e.acc = cyc;
        sb.push_back(e);
    endtask

    // Present a transaction until accepted; the expectation is queued at the moment of acceptance.
    task automatic send_exp(input logic [63:0] d, input logic [5:0] sh, input logic [1:0] m,
                            input logic [3:0] t, input logic [63:0] ed, input logic est);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = d; in_shamt = sh; in_mode = m; in_tag = t;
            #1;
            if (in_ready) begin
                push_exp(ed, t, est);
                done = 1'b1;
            end else if (++n > 200) begin
                total++; bad++;
                $display("FAIL send_timeout: tag=%0d not accepted after %0d cycles, need accept", t, n);
                in_valid = 1'b0;
                done = 1'b1;
            end
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [5:0] sh, input logic [1:0] m,
                        input logic [3:0] t);
        send_exp(d, sh, m, t, ref_shift(d, sh, m), ref_sticky(d, sh, m));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            in_valid = 1'b0;
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d results outstanding, need 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] need);
        total++;
        if (got !== need) begin
            bad++;
            $display("FAIL %s: got %h, need %h", name, got, need);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ordy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: output handshakes pop the scoreboard; stalled outputs must hold still.
    initial begin
        bit          stalled;
        logic [63:0] h_d;
        logic [3:0]  h_t;
        logic        h_s;
        exp_t        e;
        stalled = 1'b0;
        h_d = '0; h_t = '0; h_s = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    total++;
                    if (!(out_valid === 1'b1 && out_data === h_d && out_tag === h_t && out_sticky === h_s)) begin
                        bad++;
                        $display("FAIL hold_stable: got v=%0b d=%h t=%0d s=%0b, need v=1 d=%h t=%0d s=%0b",
                                 out_valid, out_data, out_tag, out_sticky, h_d, h_t, h_s);
                    end
                end
                if (out_valid && out_ready) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_out: got d=%h t=%0d, need no output", out_data, out_tag);
                    end else begin
                        e = sb.pop_front();
                        if (out_data !== e.d || out_tag !== e.t || out_sticky !== e.st) begin
                            bad++;
                            $display("FAIL result: got d=%h t=%0d s=%0b, need d=%h t=%0d s=%0b",
                                     out_data, out_tag, out_sticky, e.d, e.t, e.st);
                        end
                        if (chk_lat) begin
                            total++;
                            if (cyc - e.acc != LAT) begin
                                bad++;
                                $display("FAIL latency: got %0d cycles, need %0d", cyc - e.acc, LAT);
                            end
                        end
                    end
                end
                stalled = out_valid && !out_ready;
                h_d = out_data; h_t = out_tag; h_s = out_sticky;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        int          n;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_tag", {60'd0, out_tag}, 64'd0);
        chk("rst_out_sticky", {63'd0, out_sticky}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with latency checking
        chk_lat = 1'b1;
        ordy_mode = 0;
        send_exp(64'h1, 6'd63, 2'd0, 4'd1, 64'h8000_0000_0000_0000, 1'b0);
        send_exp(64'h8000_0000_0000_0000, 6'd4, 2'd2, 4'd2, 64'hF800_0000_0000_0000, 1'b0);
        send_exp(64'h8000_0000_0000_0000, 6'd4, 2'd1, 4'd3, 64'h0800_0000_0000_0000, 1'b0);
        send_exp(64'h8000_0000_0000_0001, 6'd1, 2'd3, 4'd4, 64'h3, 1'b0);
        send_exp(64'h8000_0000_0000_0001, 6'd0, 2'd3, 4'd5, 64'h8000_0000_0000_0001, 1'b0);
        for (int m = 0; m < 3; m++)
            send_exp(64'hDEAD_BEEF_0123_4567, 6'd0, 2'(m), 4'(6 + m), 64'hDEAD_BEEF_0123_4567, 1'b0);
        send_exp(64'h1F, 6'd4, 2'd1, 4'd9, 64'h1, STK);
        send_exp(64'h10, 6'd4, 2'd1, 4'd10, 64'h1, 1'b0);
        send_exp(64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 2'd2, 4'd11, 64'hFFFF_FFFF_FFFF_FFFF, STK);
        send_exp(64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 2'd0, 4'd12, 64'h8000_0000_0000_0000, 1'b0);
        idle(1);
        wait_drain("drain_directed");
        chk_lat = 1'b0;

        // Backpressure: three fill the pipeline, the fourth is refused while stalled
        ordy_mode = 1;
        idle(2);
        for (int t = 1; t <= 3; t++)
            send({$urandom, $urandom}, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 4'(t));
        rd = {$urandom, $urandom};
        @(negedge clk);
        in_valid = 1'b1; in_data = rd; in_shamt = 6'd7; in_mode = 2'd3; in_tag = 4'd4;
        #1;
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        repeat (4) @(negedge clk);
        ordy_mode = 0;
        send(rd, 6'd7, 2'd3, 4'd4);
        send({$urandom, $urandom}, 6'd33, 2'd2, 4'd5);
        idle(1);
        wait_drain("drain_backpressure");

        // Reset with two transactions in flight
        ordy_mode = 1;
        idle(2);
        send(64'h1234_5678_9ABC_DEF0, 6'd5, 2'd0, 4'd13);
        send(64'h0FED_CBA9_8765_4321, 6'd9, 2'd1, 4'd14);
        idle(1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("flight_out_valid", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstf_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rstf_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rstf_out_data", out_data, 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ordy_mode = 0;
        in_valid = 1'b1; in_data = 64'hA5A5_0000_FFFF_5A5A; in_shamt = 6'd16; in_mode = 2'd3; in_tag = 4'd15;
        #1;
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
        push_exp(ref_shift(64'hA5A5_0000_FFFF_5A5A, 6'd16, 2'd3), 4'd15, 1'b0);
        idle(10);
        wait_drain("drain_after_reset");

        // Randomized traffic with random backpressure
        ordy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send({$urandom, $urandom}, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)));
        end
        idle(1);
        ordy_mode = 0;
        wait_drain("drain_random");
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning data width; legal values are powers of two from 8 to 128.
REQ-002 SHALL have parameter LVL_PER_STG, default 2, meaning mux levels per pipeline stage (1..LOG2(WIDTH)).
REQ-003 SHALL have parameter TAG_W, default 4, meaning width of the sideband tag carried alongside data.
REQ-004 SHALL derive SHW = log2(WIDTH) and STAGES = ceil(SHW/LVL_PER_STG) internally; neither is user-overridable.
REQ-005 SHALL have port clk, input, 1, the single clock; all state is on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, input transaction present.
REQ-008 SHALL have port in_ready, output, 1, block accepts input this cycle.
REQ-009 SHALL have port in_data, input, WIDTH, operand.
REQ-010 SHALL have port in_shamt, input, SHW, shift amount 0..WIDTH-1.
REQ-011 SHALL have port in_mode, input, 2, operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-012 SHALL have port in_tag, input, TAG_W, opaque sideband.
REQ-013 SHALL have port out_valid, output, 1, result present.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-015 SHALL have port out_data, output, WIDTH, shifted result.
REQ-016 SHALL have port out_tag, output, TAG_W, in_tag of the same transaction.
REQ-017 SHALL have port out_sticky, output, 1, OR of bits shifted out (see Configuration).

Function
REQ-018 SHALL implement a log-shifter: level k applies a shift of 2^k when in_shamt[k]=1, levels in ascending k.
REQ-019 SHALL register after every LVL_PER_STG levels (last stage may hold fewer); latency is exactly STAGES cycles from accept to out_valid (3 for defaults).
REQ-020 SLL SHALL zero-fill the low bits; SRL SHALL zero-fill the high bits; SRA SHALL fill the high bits with in_data[WIDTH-1]; ROL SHALL rotate left with no bit lost.
REQ-021 A shamt of 0 SHALL pass in_data unchanged in every mode.
REQ-022 A transfer SHALL occur on an edge where valid and ready are both 1, on either side.
REQ-023 SHALL use a global advance enable adv = !out_valid || out_ready; all stages shift one place when adv=1 and hold when adv=0.
REQ-024 in_ready SHALL equal adv, combinationally; in_valid while in_ready=0 SHALL be ignored and SHALL NOT be captured.
REQ-025 out_data, out_tag and out_sticky SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 Bubbles (stage valid=0) SHALL propagate; throughput SHALL be one result per cycle when out_ready stays 1.
REQ-027 Results SHALL emerge in acceptance order with no loss or duplication.
REQ-028 mode and tag SHALL be pipelined alongside the data, so back-to-back transactions with different modes are independent.

Reset
REQ-029 On rst_n=0 all stage valid bits and out_valid SHALL clear to 0 asynchronously; data, tag and sticky registers SHALL clear to 0.
REQ-030 Transactions in flight at reset assertion SHALL be discarded; in_ready SHALL read 1 during and after reset.
REQ-031 Reset release SHALL be synchronised by the integrator; the block SHALL accept input on the first edge after release.

Configuration
REQ-032 With macro BSH_STICKY_EN defined, out_sticky SHALL be the OR of the in_data bits discarded by SRL/SRA (positions below shamt), accumulated per level through the pipeline; for SLL and ROL it SHALL be 0.
REQ-033 Without BSH_STICKY_EN, out_sticky SHALL be tied to 0 and no sticky registers SHALL be synthesised.

Verification (WIDTH=64, LVL_PER_STG=2)
REQ-034 SLL: in_data=0x1, shamt=63 -> out_data=0x8000_0000_0000_0000, out_valid exactly 3 cycles after accept.
REQ-035 SRA: in_data=0x8000_0000_0000_0000, shamt=4 -> out_data=0xF800_0000_0000_0000; SRL with the same inputs -> 0x0800_0000_0000_0000.
REQ-036 ROL: in_data=0x8000_0000_0000_0001, shamt=1 -> out_data=0x3; shamt=0 -> output unchanged.
REQ-037 Backpressure: 5 back-to-back transactions with tags 1..5 and out_ready=0 -> in_ready drops after the pipeline fills, out_data is held stable, and after out_ready=1 tags emerge 1..5 in order.
REQ-038 Sticky (macro defined): SRL in_data=0x1F, shamt=4 -> out_data=0x1, out_sticky=1; in_data=0x10, shamt=4 -> out_sticky=0.
REQ-039 Reset mid-flight: assert rst_n=0 with 2 transactions in flight -> out_valid=0 immediately, and neither transaction appears after release.
